// File: rtl/nmi_rr_arbiter.sv
// Round-robin arbiter sharing one NMI slave port between NUM_MST masters,
// with a watchdog that force-completes transactions the slave never acks.
module nmi_rr_arbiter #(
   parameter int          NUM_MST       = 2,
   parameter int          TIMEOUT_CYC   = 1024,
   parameter logic [31:0] TIMEOUT_RDATA = 32'hDEAD_BEEF
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic [NUM_MST-1:0]      m_valid_i,
   input  logic [NUM_MST*32-1:0]   m_addr_i,
   input  logic [NUM_MST*32-1:0]   m_wdata_i,
   input  logic [NUM_MST*4-1:0]    m_wstrb_i,
   output logic [NUM_MST*32-1:0]   m_rdata_o,
   output logic [NUM_MST-1:0]      m_ready_o,
   output logic                    s_valid_o,
   output logic [31:0]             s_addr_o,
   output logic [31:0]             s_wdata_o,
   output logic [3:0]              s_wstrb_o,
   input  logic [31:0]             s_rdata_i,
   input  logic                    s_ready_i,
   output logic [NUM_MST-1:0]      grant_o,
   output logic                    timeout_o
);

   localparam int PW    = (NUM_MST > 2) ? $clog2(NUM_MST) : 1;
   localparam int CW    = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
   localparam int TLIM  = (TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0;
   localparam bit WD_ON = (TIMEOUT_CYC > 0);

   typedef enum logic {IDLE, BUSY} state_t;

   state_t               state_q, state_d;
   logic [NUM_MST-1:0]   grant_q, grant_d;
   logic [PW-1:0]        gidx_q, gidx_d;
   logic [PW-1:0]        ptr_q, ptr_d;
   logic [CW-1:0]        cnt_q, cnt_d;

   logic [31:0]          addr_a  [NUM_MST];
   logic [31:0]          wdata_a [NUM_MST];
   logic [3:0]           wstrb_a [NUM_MST];
   logic [31:0]          rdata_a [NUM_MST];

   logic                 busy;
   logic                 g_valid;
   logic                 fire;
   logic                 found;
   logic [PW-1:0]        pick;
   logic [PW-1:0]        ptr_nx;

   for (genvar k = 0; k < NUM_MST; k++) begin : g_unpack
      assign addr_a[k]  = m_addr_i[32*k +: 32];
      assign wdata_a[k] = m_wdata_i[32*k +: 32];
      assign wstrb_a[k] = m_wstrb_i[4*k +: 4];
      assign m_rdata_o[32*k +: 32] = rdata_a[k];
   end

   assign busy    = (state_q == BUSY);
   assign g_valid = m_valid_i[gidx_q];
   assign ptr_nx  = (gidx_q == PW'(NUM_MST - 1)) ? '0 : gidx_q + 1'b1;
   // Slave response in the limit cycle wins over the watchdog.
   assign fire    = WD_ON && busy && g_valid && !s_ready_i &&
                    (cnt_q == CW'(TLIM));

   always_comb begin
      found = 1'b0;
      pick  = '0;
      for (int i = 0; i < NUM_MST; i++) begin
         int idx;
         idx = int'(ptr_q) + i;
         if (idx >= NUM_MST) idx = idx - NUM_MST;
         if (!found && m_valid_i[PW'(idx)]) begin
            found = 1'b1;
            pick  = PW'(idx);
         end
      end
   end

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      gidx_d  = gidx_q;
      ptr_d   = ptr_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         IDLE: begin
            if (found) begin
               state_d = BUSY;
               gidx_d  = pick;
               grant_d = NUM_MST'(1) << pick;
               cnt_d   = '0;
            end
         end
         BUSY: begin
            if (!g_valid || s_ready_i || fire) begin
               state_d = IDLE;
               grant_d = '0;
               ptr_d   = ptr_nx;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         grant_q <= '0;
         gidx_q  <= '0;
         ptr_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         gidx_q  <= gidx_d;
         ptr_q   <= ptr_d;
         cnt_q   <= cnt_d;
      end
   end

   // Outputs are gated by reset so an abandoned transaction gets no ready.
   always_comb begin
      s_valid_o = 1'b0;
      s_addr_o  = '0;
      s_wdata_o = '0;
      s_wstrb_o = '0;
      m_ready_o = '0;
      for (int k = 0; k < NUM_MST; k++) rdata_a[k] = '0;
      if (busy && !rst_i) begin
         s_valid_o         = g_valid && !fire;
         s_addr_o          = addr_a[gidx_q];
         s_wdata_o         = wdata_a[gidx_q];
         s_wstrb_o         = wstrb_a[gidx_q];
         m_ready_o[gidx_q] = g_valid && (s_ready_i || fire);
         rdata_a[gidx_q]   = fire ? TIMEOUT_RDATA : s_rdata_i;
      end
   end

   assign grant_o   = rst_i ? '0 : grant_q;
   assign timeout_o = fire && !rst_i;

endmodule

// File: tb/tb_nmi_rr_arbiter.sv
// Directed bench for nmi_rr_arbiter: per-cycle vector table plus
// hand-written watchdog and reset sequences.
module tb_nmi_rr_arbiter;

   localparam logic [31:0] A0 = 32'h3000_0000;
   localparam logic [31:0] W0 = 32'h1111_1111;
   localparam logic [3:0]  S0 = 4'b0000;
   localparam logic [31:0] A1 = 32'h1000_0004;
   localparam logic [31:0] W1 = 32'hA5A5_A5A5;
   localparam logic [3:0]  S1 = 4'b0011;

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b1;
   logic [1:0]  m_valid_i = 2'b11;
   logic [63:0] m_addr_i  = {A1, A0};
   logic [63:0] m_wdata_i = {W1, W0};
   logic [7:0]  m_wstrb_i = {S1, S0};
   logic [63:0] m_rdata_o;
   logic [1:0]  m_ready_o;
   logic        s_valid_o;
   logic [31:0] s_addr_o;
   logic [31:0] s_wdata_o;
   logic [3:0]  s_wstrb_o;
   logic [31:0] s_rdata_i = '0;
   logic        s_ready_i = 1'b0;
   logic [1:0]  grant_o;
   logic        timeout_o;

   int n_cmp = 0;
   int n_bad = 0;

   nmi_rr_arbiter #(
      .NUM_MST(2), .TIMEOUT_CYC(8), .TIMEOUT_RDATA(32'hDEAD_BEEF)
   ) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .m_valid_i(m_valid_i), .m_addr_i(m_addr_i),
      .m_wdata_i(m_wdata_i), .m_wstrb_i(m_wstrb_i),
      .m_rdata_o(m_rdata_o), .m_ready_o(m_ready_o),
      .s_valid_o(s_valid_o), .s_addr_o(s_addr_o),
      .s_wdata_o(s_wdata_o), .s_wstrb_o(s_wstrb_o),
      .s_rdata_i(s_rdata_i), .s_ready_i(s_ready_i),
      .grant_o(grant_o), .timeout_o(timeout_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic        rst;
      logic [1:0]  mv;
      logic        sr;
      logic [31:0] rd;
      logic [1:0]  eg;
      logic [1:0]  emr;
      logic        esv;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(logic r, logic [1:0] mv, logic sr,
                               logic [31:0] rd, logic [1:0] eg,
                               logic [1:0] emr, logic esv);
      vec_t v;
      v.rst = r; v.mv = mv; v.sr = sr; v.rd = rd;
      v.eg = eg; v.emr = emr; v.esv = esv;
      return v;
   endfunction

   task automatic cyc(input logic r, input logic [1:0] mv,
                      input logic sr, input logic [31:0] rd);
      @(posedge clk_i);
      #1;
      rst_i = r; m_valid_i = mv; s_ready_i = sr; s_rdata_i = rd;
      #1;
   endtask

   task automatic chk(input string nm, input logic [137:0] act,
                      input logic [137:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   function automatic logic [137:0] pack_dut();
      return {grant_o, m_ready_o, s_valid_o, timeout_o,
              s_addr_o, s_wdata_o, s_wstrb_o, m_rdata_o};
   endfunction

   function automatic logic [137:0] pack_exp(vec_t v);
      logic [31:0] a, w;
      logic [3:0]  s;
      logic [63:0] r;
      a = '0; w = '0; s = '0; r = '0;
      if (v.eg == 2'b01) begin a = A0; w = W0; s = S0; r = {32'h0, v.rd}; end
      if (v.eg == 2'b10) begin a = A1; w = W1; s = S1; r = {v.rd, 32'h0}; end
      return {v.eg, v.emr, v.esv, 1'b0, a, w, s, r};
   endfunction

   initial begin
      // reset with both requesting
      tbl.push_back(mk(1, 2'b11, 0, 0, 2'b00, 2'b00, 0));
      tbl.push_back(mk(1, 2'b11, 0, 0, 2'b00, 2'b00, 0));
      tbl.push_back(mk(1, 2'b11, 0, 0, 2'b00, 2'b00, 0));
      tbl.push_back(mk(0, 2'b01, 0, 0, 2'b00, 2'b00, 0));
      // single read of M0, slave ready after 2 cycles
      tbl.push_back(mk(0, 2'b01, 0, 0, 2'b01, 2'b00, 1));
      tbl.push_back(mk(0, 2'b01, 0, 0, 2'b01, 2'b00, 1));
      tbl.push_back(mk(0, 2'b01, 1, 32'h1234_5678, 2'b01, 2'b01, 1));
      tbl.push_back(mk(0, 2'b00, 0, 0, 2'b00, 2'b00, 0));
      // contention, zero-wait slave; ptr now at M1
      tbl.push_back(mk(0, 2'b11, 1, 0, 2'b00, 2'b00, 0));
      tbl.push_back(mk(0, 2'b11, 1, 0, 2'b10, 2'b10, 1));
      tbl.push_back(mk(0, 2'b11, 1, 0, 2'b00, 2'b00, 0));
      tbl.push_back(mk(0, 2'b11, 1, 0, 2'b01, 2'b01, 1));
      tbl.push_back(mk(0, 2'b11, 1, 0, 2'b00, 2'b00, 0));
      tbl.push_back(mk(0, 2'b11, 1, 0, 2'b10, 2'b10, 1));
      tbl.push_back(mk(0, 2'b00, 0, 0, 2'b00, 2'b00, 0));
      // M1 write routing
      tbl.push_back(mk(0, 2'b10, 0, 0, 2'b00, 2'b00, 0));
      tbl.push_back(mk(0, 2'b10, 0, 0, 2'b10, 2'b00, 1));
      tbl.push_back(mk(0, 2'b10, 1, 0, 2'b10, 2'b10, 1));
      tbl.push_back(mk(0, 2'b00, 0, 0, 2'b00, 2'b00, 0));
      // M0 drops valid while granted: no ready, ptr advances
      tbl.push_back(mk(0, 2'b01, 0, 0, 2'b00, 2'b00, 0));
      tbl.push_back(mk(0, 2'b00, 1, 0, 2'b01, 2'b00, 0));
      tbl.push_back(mk(0, 2'b11, 0, 0, 2'b00, 2'b00, 0));
      tbl.push_back(mk(0, 2'b10, 0, 0, 2'b10, 2'b00, 1));
      tbl.push_back(mk(0, 2'b10, 1, 0, 2'b10, 2'b10, 1));
      tbl.push_back(mk(0, 2'b00, 0, 0, 2'b00, 2'b00, 0));

      foreach (tbl[i]) begin
         cyc(tbl[i].rst, tbl[i].mv, tbl[i].sr, tbl[i].rd);
         chk($sformatf("vec%0d", i), pack_dut(), pack_exp(tbl[i]));
      end

      // watchdog on M0 (ptr at 0): fires in 8th BUSY cycle
      cyc(0, 2'b11, 0, 0);
      chk("to_idle", {136'h0, grant_o}, 138'h0);
      for (int c = 1; c <= 7; c++) begin
         cyc(0, 2'b11, 0, 0);
         chk($sformatf("to_wait%0d", c),
             {132'h0, grant_o, m_ready_o, s_valid_o, timeout_o},
             {132'h0, 2'b01, 2'b00, 1'b1, 1'b0});
      end
      cyc(0, 2'b11, 0, 0);
      chk("to_fire",
          {100'h0, grant_o, m_ready_o, s_valid_o, timeout_o,
           m_rdata_o[31:0]},
          {100'h0, 2'b01, 2'b01, 1'b0, 1'b1, 32'hDEAD_BEEF});
      cyc(0, 2'b11, 0, 0);
      chk("to_after", {132'h0, grant_o, m_ready_o, s_valid_o, timeout_o},
          138'h0);

      // M1 next; slave ready lands exactly in the limit cycle
      for (int c = 1; c <= 7; c++) begin
         cyc(0, 2'b11, 0, 0);
         chk($sformatf("race_wait%0d", c),
             {132'h0, grant_o, m_ready_o, s_valid_o, timeout_o},
             {132'h0, 2'b10, 2'b00, 1'b1, 1'b0});
      end
      cyc(0, 2'b11, 1, 32'h55AA_55AA);
      chk("race_slave",
          {100'h0, grant_o, m_ready_o, s_valid_o, timeout_o,
           m_rdata_o[63:32]},
          {100'h0, 2'b10, 2'b10, 1'b1, 1'b0, 32'h55AA_55AA});

      // complete M0 so ptr points at M1, then reset mid-BUSY on M1
      cyc(0, 2'b11, 0, 0);
      cyc(0, 2'b11, 1, 0);
      chk("pre_m0", {134'h0, grant_o, m_ready_o}, {134'h0, 2'b01, 2'b01});
      cyc(0, 2'b11, 0, 0);
      cyc(0, 2'b11, 0, 0);
      chk("pre_m1", {136'h0, grant_o}, {136'h0, 2'b10});
      cyc(1, 2'b11, 1, 32'h0BAD_0BAD);
      chk("rst_mid", pack_dut(), 138'h0);
      cyc(0, 2'b11, 0, 0);
      chk("rst_idle", pack_dut(), 138'h0);
      cyc(0, 2'b11, 0, 0);
      chk("rst_restart", {136'h0, grant_o}, {136'h0, 2'b01});

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL watchdog: bench timed out");
      $fatal(1);
   end

endmodule

// File: doc/nmi_rr_arbiter.md
Name: nmi_rr_arbiter

Overview:
- Round-robin arbiter that shares one native memory interface (NMI) slave port between NUM_MST requesters, e.g. the management core and a DMA engine.
- NMI uses valid/addr/wdata/wstrb/rdata/ready. wstrb==0 is a read. A requester holds valid and its request fields stable until it sees ready.
- The block sits between the masters and the SoC address decoder. A watchdog completes any transaction the slave never acknowledges.

Parameters:
- NUM_MST, 2, number of requesters (2..8).
- TIMEOUT_CYC, 1024, BUSY cycles before forced completion; 0 disables the watchdog.
- TIMEOUT_RDATA, 32'hDEAD_BEEF, read data returned on a timeout.

Ports:
- clk_i  in  1  system clock.
- rst_i  in  1  synchronous reset, active-high.
- m_valid_i  in  NUM_MST  per-master request valid.
- m_addr_i  in  NUM_MST*32  per-master address, master k at bits [32k+31:32k].
- m_wdata_i  in  NUM_MST*32  per-master write data.
- m_wstrb_i  in  NUM_MST*4  per-master byte strobes.
- m_rdata_o  out  NUM_MST*32  per-master read data.
- m_ready_o  out  NUM_MST  per-master completion.
- s_valid_o  out  1  slave request valid.
- s_addr_o  out  32  slave address.
- s_wdata_o  out  32  slave write data.
- s_wstrb_o  out  4  slave strobes.
- s_rdata_i  in  32  slave read data.
- s_ready_i  in  1  slave completion.
- grant_o  out  NUM_MST  one-hot current grant; 0 when IDLE.
- timeout_o  out  1  one-cycle pulse when the watchdog fires.

Behaviour:
- Reset (rst_i high at a clock edge):
  - state=IDLE, rr_ptr=0, grant=0, watchdog counter=0.
  - All outputs 0, including s_valid_o, m_ready_o, timeout_o and grant_o.
  - Reset mid-transaction abandons the transaction with no ready to any master.
- State IDLE:
  - If any m_valid_i is set, pick the first set bit scanning from rr_ptr upward, wrapping modulo NUM_MST.
  - Register the one-hot grant and go to BUSY.
  - No slave traffic in IDLE; arbitration costs exactly 1 cycle.
- State BUSY:
  - s_valid/addr/wdata/wstrb are combinationally muxed from the granted master: s_valid_o = m_valid_i[g].
  - m_ready_o[g] = s_ready_i and m_rdata_o[g] = s_rdata_i, both combinational.
  - Non-granted masters see ready=0 and rdata=0.
  - On s_ready_i: go to IDLE, set rr_ptr=(g+1) mod NUM_MST, clear grant. The granted master gets its single ready in this cycle.
- Zero-wait slave latency: request seen in cycle N, grant in N+1, ready no earlier than N+1. Back-to-back grants are separated by one IDLE cycle.
- Granted master drops valid in BUSY (protocol violation): return to IDLE next cycle, rr_ptr advances, no ready issued.
- Watchdog (TIMEOUT_CYC>0):
  - Counter clears on entry to BUSY and increments on each BUSY cycle without s_ready_i.
  - When the counter reaches TIMEOUT_CYC-1 and s_ready_i is still low: that cycle forces s_valid_o=0, m_ready_o[g]=1 and m_rdata_o[g]=TIMEOUT_RDATA, and pulses timeout_o.
  - The arbiter then goes to IDLE and advances rr_ptr.
  - If s_ready_i arrives in the same cycle the watchdog would fire, the slave response wins and timeout_o stays 0.
- Fairness: a master waits at most NUM_MST-1 other transactions. A continuously requesting master cannot starve others.
- Single master requesting repeatedly: it is re-granted after each IDLE cycle.
- Requests are never reordered or duplicated; exactly one ready per granted transaction.

Test Plan:
- Reset: hold rst_i 3 cycles with m_valid_i=2'b11 -> all outputs 0; after release, grant_o=2'b01 one cycle later.
- Single read: M0 valid, addr 0x3000_0000, wstrb 0; slave ready 2 cycles after s_valid_o with rdata 0x1234_5678 -> m_ready_o[0] pulses once with m_rdata_o[0]=0x1234_5678; M1 outputs stay 0.
- Round-robin contention: M0 and M1 both valid continuously, slave zero-wait -> grants alternate 01,10,01,10; one IDLE cycle between each.
- Write routing: M1 write addr 0x1000_0004, wdata 0xA5A5_A5A5, wstrb 4'b0011 -> slave sees exactly those values; ready is returned only to M1.
- Timeout: TIMEOUT_CYC=8, slave never ready -> after 8 BUSY cycles m_ready_o[g]=1, rdata=0xDEAD_BEEF, timeout_o pulses 1 cycle; next master is granted afterward.
- Edge cases:
  - s_ready_i exactly in the timeout cycle -> slave data returned, timeout_o=0.
  - rst_i asserted mid-BUSY -> no ready issued; arbitration restarts from M0.
